// File: rtl/simmem_rsp_bank_inorder.sv
// Response bank with per-ID in-order release: slots are reserved, filled by the
// memory side, then handed back to the requester in reservation order per ID.
module simmem_rsp_bank_inorder #(
    parameter int NumIds   = 4,
    parameter int Capacity = 8,
    parameter int DataW    = 16,
    localparam int IdW     = $clog2(NumIds),
    localparam int AddrW   = $clog2(Capacity),
    localparam int TktW    = AddrW + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rsv_valid_i,
    output logic                rsv_ready_o,
    input  logic [IdW-1:0]      rsv_id_i,
    output logic [AddrW-1:0]    rsv_iid_o,
    input  logic                in_rsp_valid_i,
    output logic                in_rsp_ready_o,
    input  logic [IdW-1:0]      in_rsp_id_i,
    input  logic [DataW-1:0]    in_rsp_data_i,
    input  logic [Capacity-1:0] release_en_i,
    output logic                out_rsp_valid_o,
    input  logic                out_rsp_ready_i,
    output logic [IdW-1:0]      out_rsp_id_o,
    output logic [DataW-1:0]    out_rsp_data_o,
    output logic [Capacity-1:0] released_addr_onehot_o,
    output logic [AddrW:0]      occupancy_o
);

    typedef enum logic [1:0] {
        SlotFree,
        SlotReserved,
        SlotFilled
    } slot_state_e;

    slot_state_e      state_q   [Capacity];
    slot_state_e      state_d   [Capacity];
    logic [IdW-1:0]   slot_id_q [Capacity];
    logic [TktW-1:0]  slot_tkt_q[Capacity];
    logic [DataW-1:0] slot_data_q[Capacity];

    logic [TktW-1:0]  rsv_tkt_q [NumIds];
    logic [TktW-1:0]  fill_tkt_q[NumIds];
    logic [TktW-1:0]  rel_tkt_q [NumIds];

    logic [AddrW:0]   occupancy_q;
    logic [AddrW-1:0] fill_idx;
    logic [AddrW-1:0] out_idx;
    logic             rsv_hs;
    logic             in_hs;
    logic             out_hs;

    // Slot selection: every decision looks only at registered slot state, so a
    // slot changing state this cycle cannot be picked again until the next one.
    always_comb begin
        rsv_ready_o     = 1'b0;
        rsv_iid_o       = '0;
        in_rsp_ready_o  = 1'b0;
        fill_idx        = '0;
        out_rsp_valid_o = 1'b0;
        out_idx         = '0;
        for (int i = Capacity - 1; i >= 0; i--) begin
            if (state_q[i] == SlotFree) begin
                rsv_ready_o = 1'b1;
                rsv_iid_o   = AddrW'(i);
            end
            if (state_q[i] == SlotReserved && slot_id_q[i] == in_rsp_id_i &&
                slot_tkt_q[i] == fill_tkt_q[in_rsp_id_i]) begin
                in_rsp_ready_o = 1'b1;
                fill_idx       = AddrW'(i);
            end
            if (state_q[i] == SlotFilled && release_en_i[i] &&
                slot_tkt_q[i] == rel_tkt_q[slot_id_q[i]]) begin
                out_rsp_valid_o = 1'b1;
                out_idx         = AddrW'(i);
            end
        end
    end

    assign rsv_hs = rsv_valid_i & rsv_ready_o;
    assign in_hs  = in_rsp_valid_i & in_rsp_ready_o;
    assign out_hs = out_rsp_valid_o & out_rsp_ready_i;

    always_comb begin
        out_rsp_id_o           = '0;
        out_rsp_data_o         = '0;
        released_addr_onehot_o = '0;
        if (out_rsp_valid_o) begin
            out_rsp_id_o   = slot_id_q[out_idx];
            out_rsp_data_o = slot_data_q[out_idx];
        end
        if (out_hs) begin
            released_addr_onehot_o[out_idx] = 1'b1;
        end
    end

    // The three handshakes always target slots in different states, so they
    // never collide on the same slot.
    always_comb begin
        for (int i = 0; i < Capacity; i++) begin
            state_d[i] = state_q[i];
        end
        if (rsv_hs) state_d[rsv_iid_o] = SlotReserved;
        if (in_hs)  state_d[fill_idx]  = SlotFilled;
        if (out_hs) state_d[out_idx]   = SlotFree;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Capacity; i++) begin
                state_q[i] <= SlotFree;
            end
        end else begin
            for (int i = 0; i < Capacity; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Capacity; i++) begin
                slot_id_q[i]   <= '0;
                slot_tkt_q[i]  <= '0;
                slot_data_q[i] <= '0;
            end
            for (int k = 0; k < NumIds; k++) begin
                rsv_tkt_q[k]  <= '0;
                fill_tkt_q[k] <= '0;
                rel_tkt_q[k]  <= '0;
            end
            occupancy_q <= '0;
        end else begin
            if (rsv_hs) begin
                slot_id_q[rsv_iid_o]  <= rsv_id_i;
                slot_tkt_q[rsv_iid_o] <= rsv_tkt_q[rsv_id_i];
                rsv_tkt_q[rsv_id_i]   <= rsv_tkt_q[rsv_id_i] + TktW'(1);
            end
            if (in_hs) begin
                slot_data_q[fill_idx]   <= in_rsp_data_i;
                fill_tkt_q[in_rsp_id_i] <= fill_tkt_q[in_rsp_id_i] + TktW'(1);
            end
            if (out_hs) begin
                rel_tkt_q[out_rsp_id_o] <= rel_tkt_q[out_rsp_id_o] + TktW'(1);
            end
            case ({rsv_hs, out_hs})
                2'b10:   occupancy_q <= occupancy_q + (AddrW + 1)'(1);
                2'b01:   occupancy_q <= occupancy_q - (AddrW + 1)'(1);
                default: occupancy_q <= occupancy_q;
            endcase
        end
    end

    assign occupancy_o = occupancy_q;

endmodule
